// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// mod_counter : prescaled up/down modulo counter with one-shot stop and TC
// Rev 1.0
// ============================================================================
module mod_counter #(
   parameter int WIDTH    = 8,
   parameter int MAXVAL   = 255,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             oneshot,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    c_PLAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MAXVAL);

   logic [PW-1:0]    r_pcnt;
   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_done;

   logic             w_tick;
   logic [WIDTH-1:0] w_term;
   logic [WIDTH-1:0] w_load_sat;

   // With PRESCALE=1 the prescaler never leaves 0, so tick degenerates to en.
   assign w_tick     = en && (r_pcnt == c_PLAST);
   assign w_term     = up ? c_MAX : '0;
   assign w_load_sat = (load_val > c_MAX) ? c_MAX : load_val;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_pcnt <= '0;
         r_q    <= '0;
         r_tc   <= 1'b0;
         r_done <= 1'b0;
      end else if (load) begin
         r_pcnt <= '0;
         r_q    <= w_load_sat;
         r_tc   <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (en) begin
            r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
         end
         // A completed one-shot freezes q until load or clr re-arms it.
         if (w_tick && !r_done) begin
            if (r_q == w_term) begin
               r_tc <= 1'b1;
               if (oneshot) begin
                  r_done <= 1'b1;
               end else begin
                  r_q <= up ? '0 : c_MAX;
               end
            end else begin
               r_q <= up ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
            end
         end
      end
   end

   assign q    = r_q;
   assign tc   = r_tc;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// tb_mod_counter : directed self-checking bench, WIDTH=4 MAXVAL=9 PRESCALE=3
// Rev 1.0
// ============================================================================
module tb_mod_counter;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       oneshot = 1'b0;
   logic [3:0] q;
   logic       tc;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;

   mod_counter #(.WIDTH(4), .MAXVAL(9), .PRESCALE(3)) dut (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .oneshot  (oneshot),
      .q        (q),
      .tc       (tc),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [3:0] eq, input logic etc, input logic edone);
      chk({tag, ".q"}, 32'(q), 32'(eq));
      chk({tag, ".tc"}, 32'(tc), 32'(etc));
      chk({tag, ".done"}, 32'(done), 32'(edone));
   endtask

   initial begin
      // Reset state
      clr = 1'b1;
      cyc();
      chk3("reset", 4'd0, 1'b0, 1'b0);

      // 30 enabled up-count cycles: a step every 3rd cycle, wrap on the 30th
      clr = 1'b0; en = 1'b1; up = 1'b1; oneshot = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         chk3($sformatf("run%0d", i), (i == 30) ? 4'd0 : 4'(i / 3), (i == 30), 1'b0);
      end
      en = 1'b0;
      cyc();
      chk3("run_after", 4'd0, 1'b0, 1'b0);

      // Load saturates at MAXVAL
      load = 1'b1; load_val = 4'd15;
      cyc();
      chk3("load_sat", 4'd9, 1'b0, 1'b0);
      // Load wins over en and clears the prescaler
      load_val = 4'd4; en = 1'b1;
      cyc();
      chk3("load_en", 4'd4, 1'b0, 1'b0);
      load = 1'b0;
      cyc();
      chk("pcnt0_a.q", 32'(q), 32'd4);
      cyc();
      chk("pcnt0_b.q", 32'(q), 32'd4);
      cyc();
      chk("pcnt0_c.q", 32'(q), 32'd5);

      // Down-count wrap from 0 to MAXVAL
      en = 1'b0; load = 1'b1; load_val = 4'd0;
      cyc();
      chk("ld0.q", 32'(q), 32'd0);
      load = 1'b0; up = 1'b0; en = 1'b1;
      cyc();
      cyc();
      chk3("dn_wrap_pre", 4'd0, 1'b0, 1'b0);
      cyc();
      chk3("dn_wrap", 4'd9, 1'b1, 1'b0);
      en = 1'b0;
      cyc();
      chk3("dn_wrap_after", 4'd9, 1'b0, 1'b0);

      // Plain decrement
      load = 1'b1; load_val = 4'd5;
      cyc();
      load = 1'b0; en = 1'b1;
      cyc();
      cyc();
      cyc();
      chk3("dec", 4'd4, 1'b0, 1'b0);

      // One-shot from 8 upward
      en = 1'b0; load = 1'b1; load_val = 4'd8; up = 1'b1;
      cyc();
      load = 1'b0; oneshot = 1'b1; en = 1'b1;
      cyc();
      cyc();
      cyc();
      chk3("os_step", 4'd9, 1'b0, 1'b0);
      cyc();
      cyc();
      cyc();
      chk3("os_done", 4'd9, 1'b1, 1'b0 | 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk3($sformatf("os_frozen%0d", i), 4'd9, 1'b0, 1'b1);
      end
      // Clearing oneshot leaves done set and q frozen
      oneshot = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
      end
      chk3("os_off", 4'd9, 1'b0, 1'b1);
      // Remaining cycles bring the prescaler back to 0 before reloading
      en = 1'b0; load = 1'b1; load_val = 4'd2;
      cyc();
      chk3("os_reload", 4'd2, 1'b0, 1'b0);

      // clr beats load and a pending wrap tick at q=9
      load_val = 4'd9;
      cyc();
      load = 1'b0; en = 1'b1;
      cyc();
      cyc();
      chk3("pre_clr", 4'd9, 1'b0, 1'b0);
      clr = 1'b1; load = 1'b1; load_val = 4'd5;
      cyc();
      chk3("clr_prio", 4'd0, 1'b0, 1'b0);
      // Counting resumes from 0 with a fresh prescaler
      clr = 1'b0; load = 1'b0;
      cyc();
      cyc();
      chk3("resume_pre", 4'd0, 1'b0, 1'b0);
      cyc();
      chk3("resume", 4'd1, 1'b0, 1'b0);

      // en pattern 1,0,1,1 from pcnt=0: only the 4th cycle ticks
      en = 1'b1;
      cyc();
      chk("gap1.q", 32'(q), 32'd1);
      en = 1'b0;
      cyc();
      chk("gap2.q", 32'(q), 32'd1);
      en = 1'b1;
      cyc();
      chk("gap3.q", 32'(q), 32'd1);
      cyc();
      chk3("gap4", 4'd2, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
